cv32e41s_tcm_dma: RTL and testbench

Single-channel block-transfer initiator driving one port of the core's tightly coupled memory. A command (address, word count, direction) either streams words from a valid/ready input into the TCM (write) or reads words out of the TCM onto a valid/ready output (read). It is the requester side of the TCM port protocol:
- req/we/be/addr/wdata out;
- rvalid/rdata back exactly one cycle after each accepted req, with no grant and no backpressure.

It is used for TCM preload and debug/block copy without core involvement.

---
 rtl/cv32e41s_tcm_dma.sv | 170 +++++++++++++++++
 tb/tb_cv32e41s_tcm_dma.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_tcm_dma.sv
// Single-channel block-transfer initiator on one TCM port: streams words into the TCM
// or reads them back onto a valid/ready stream through a credit-limited return FIFO.
module cv32e41s_tcm_dma #(
    parameter int A_WID         = 32,
    parameter int CNT_WID       = 16,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_write_i,
    input  logic [A_WID-1:0]   cmd_addr_i,
    input  logic [CNT_WID-1:0] cmd_len_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [31:0]        s_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [31:0]        m_data_o,
    output logic               m_last_o,
    output logic               tcm_req_o,
    output logic               tcm_we_o,
    output logic [3:0]         tcm_be_o,
    output logic [A_WID-1:0]   tcm_addr_o,
    output logic [31:0]        tcm_wdata_o,
    input  logic               tcm_rvalid_i,
    input  logic [31:0]        tcm_rdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [OCC_W:0]   DEPTH_L = (OCC_W + 1)'(RD_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RD_FIFO_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [A_WID-1:0]   addr_q, addr_d;
    logic [CNT_WID-1:0] len_q, len_d, issued_q, issued_d, deliv_q, deliv_d;
    logic               write_q, write_d, ready_q, ready_d, err_q, err_d;
    logic [OCC_W-1:0]   outst_q, outst_d, count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]        fifo_mem [RD_FIFO_DEPTH];

    logic accept, rsp, push, pop, credit, last_issue;

    assign accept     = cmd_valid_i & ready_q;
    // A response with nothing outstanding belongs to an abandoned transfer.
    assign rsp        = tcm_rvalid_i & (outst_q != '0);
    assign push       = rsp & ~write_q;
    assign credit     = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_L;
    assign pop        = m_valid_o & m_ready_i;
    assign last_issue = (issued_q == len_q - CNT_WID'(1));

    assign cmd_ready_o = ready_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign tcm_be_o    = 4'hF;
    assign m_valid_o   = (count_q != '0);
    assign m_data_o    = m_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign m_last_o    = m_valid_o & (deliv_q == len_q - CNT_WID'(1));
    assign tcm_addr_o  = tcm_req_o ? addr_q : '0;
    assign tcm_wdata_o = (tcm_req_o & tcm_we_o) ? s_data_i : '0;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        s_ready_o = 1'b0;
        tcm_req_o = 1'b0;
        tcm_we_o  = 1'b0;
        if (state_q == WRITE) begin
            s_ready_o = 1'b1;
            tcm_req_o = s_valid_i;
            tcm_we_o  = 1'b1;
        end else if (state_q == READ) begin
            tcm_req_o = (issued_q < len_q) & credit;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        write_d  = write_q;
        err_d    = 1'b0;
        issued_d = issued_q;
        deliv_d  = deliv_q + CNT_WID'(pop);
        outst_d  = outst_q + OCC_W'(tcm_req_o) - OCC_W'(rsp);
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
        wr_ptr_d = push ? ((wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? ((rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        if (tcm_req_o) begin
            addr_d   = addr_q + A_WID'(4);
            issued_d = issued_q + CNT_WID'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = cmd_addr_i;
                        len_d    = cmd_len_i;
                        write_d  = cmd_write_i;
                        issued_d = '0;
                        deliv_d  = '0;
                        if (cmd_len_i == '0) state_d = DONE;
                        else                 state_d = cmd_write_i ? WRITE : READ;
                    end
                end
            end
            WRITE, READ: begin
                if (tcm_req_o && last_issue) state_d = WAIT;
            end
            WAIT: begin
                if (write_q) begin
                    if (outst_d == '0) state_d = DONE;
                end else if (pop && m_last_o) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            write_q  <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            issued_q <= '0;
            deliv_q  <= '0;
            outst_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            write_q  <= write_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            issued_q <= issued_d;
            deliv_q  <= deliv_d;
            outst_q  <= outst_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= tcm_rdata_i;
    end

endmodule

// File: tb/tb_cv32e41s_tcm_dma.sv
// Bench for cv32e41s_tcm_dma: a one-cycle-latency TCM model plus an expected-memory
// reference, with directed protocol scenarios and randomized write/read-back traffic.
module tb_cv32e41s_tcm_dma;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [15:0] cmd_len_i = '0;
    logic        s_valid_i = 1'b0, m_ready_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        cmd_ready_o, s_ready_o, m_valid_o, m_last_o;
    logic [31:0] m_data_o;
    logic        tcm_req_o, tcm_we_o;
    logic [3:0]  tcm_be_o;
    logic [31:0] tcm_addr_o, tcm_wdata_o;
    logic        tcm_rvalid_i = 1'b0;
    logic [31:0] tcm_rdata_i = '0;
    logic        busy_o, done_o, err_o;

    int total = 0;
    int bad = 0;
    int req_cnt = 0;
    int rd_req_cnt = 0;
    logic [31:0] tcm_mem [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];

    cv32e41s_tcm_dma #(.A_WID(32), .CNT_WID(16), .RD_FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .tcm_req_o(tcm_req_o), .tcm_we_o(tcm_we_o), .tcm_be_o(tcm_be_o),
        .tcm_addr_o(tcm_addr_o), .tcm_wdata_o(tcm_wdata_o),
        .tcm_rvalid_i(tcm_rvalid_i), .tcm_rdata_i(tcm_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // TCM: every request answered exactly one cycle later, independent of the DUT's reset.
    always @(posedge clk_i) begin
        tcm_rvalid_i <= tcm_req_o;
        tcm_rdata_i  <= 32'h0;
        if (tcm_req_o) begin
            req_cnt++;
            if (tcm_we_o) begin
                tcm_mem[tcm_addr_o] = tcm_wdata_o;
            end else begin
                rd_req_cnt++;
                tcm_rdata_i <= tcm_mem.exists(tcm_addr_o) ? tcm_mem[tcm_addr_o] : 32'hBAD0_0000;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic bit outputs_quiet();
        return cmd_ready_o === 1'b0 && s_ready_o === 1'b0 && m_valid_o === 1'b0 &&
               m_data_o === 32'h0 && m_last_o === 1'b0 && tcm_req_o === 1'b0 &&
               tcm_we_o === 1'b0 && tcm_be_o === 4'hF && tcm_addr_o === 32'h0 &&
               tcm_wdata_o === 32'h0 && busy_o === 1'b0 && done_o === 1'b0 && err_o === 1'b0;
    endfunction

    // Starts and ends on a negedge; the command is accepted at the following posedge (cycle 0).
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [15:0] n);
        int w = 0;
        #1;
        while (cmd_ready_o !== 1'b1 && w < 50) begin
            @(negedge clk_i); #1; w++;
        end
        total++;
        if (cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_timeout: cmd_ready_o=%b required 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = n;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a0, input int n, input int stall_pct,
                            input logic seq, input logic [31:0] base);
        logic [31:0] a = a0;
        logic [31:0] d;
        int i = 0;
        int cyc = 0;
        send_cmd(1'b1, a0, 16'(n));
        while (i < n && cyc < 2000) begin
            s_valid_i = ($urandom_range(0, 99) >= stall_pct);
            d = seq ? base + 32'(i) : $urandom;
            s_data_i = d;
            #1;
            total++;
            if (s_valid_i) begin
                if (tcm_req_o !== 1'b1 || tcm_we_o !== 1'b1 || tcm_be_o !== 4'hF || s_ready_o !== 1'b1 ||
                    cmd_ready_o !== 1'b0 || tcm_addr_o !== a || tcm_wdata_o !== d) begin
                    bad++;
                    $display("FAIL write_beat: req=%b we=%b be=%h addr=%h wdata=%h required req=1 we=1 be=f addr=%h wdata=%h",
                             tcm_req_o, tcm_we_o, tcm_be_o, tcm_addr_o, tcm_wdata_o, a, d);
                end
                exp_mem[a] = d;
                a += 32'd4;
                i++;
            end else if (tcm_req_o !== 1'b0 || s_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL write_stall: req=%b s_ready=%b required req=0 s_ready=1", tcm_req_o, s_ready_o);
            end
            @(negedge clk_i);
            cyc++;
        end
        s_valid_i = 1'b0;
        total++;
        if (i != n) begin
            bad++;
            $display("FAIL write_timeout: beats=%0d required %0d", i, n);
        end
        #1;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b1 || tcm_req_o !== 1'b0 || s_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL write_wait: done=%b busy=%b req=%b s_ready=%b required 0 1 0 0",
                     done_o, busy_o, tcm_req_o, s_ready_o);
        end
        @(negedge clk_i); #1;
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL write_done: done=%b required 1 two cycles after last beat", done_o);
        end
        @(negedge clk_i); #1;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL write_idle: done=%b busy=%b cmd_ready=%b required 0 0 1", done_o, busy_o, cmd_ready_o);
        end
        @(negedge clk_i);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic do_read(input logic [31:0] a0, input int n, input int mode,
                           output int first_req, output int first_valid, output int last_cyc);
        int k = 0;
        int cyc = 1;
        int rd0 = rd_req_cnt;
        int inflight;
        logic held = 1'b0;
        logic hlast = 1'b0;
        logic [31:0] hdata = '0;
        logic [31:0] exp;
        first_req = -1; first_valid = -1; last_cyc = -1;
        send_cmd(1'b0, a0, 16'(n));
        while (k < n && cyc < 2000) begin
            case (mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ((cyc - 1) % 3 == 0);
                default: m_ready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (first_req < 0 && tcm_req_o === 1'b1) first_req = cyc;
            if (first_valid < 0 && m_valid_o === 1'b1) first_valid = cyc;
            if (held) begin
                total++;
                if (m_valid_o !== 1'b1 || m_data_o !== hdata || m_last_o !== hlast) begin
                    bad++;
                    $display("FAIL read_hold: valid=%b data=%h last=%b required 1 %h %b",
                             m_valid_o, m_data_o, m_last_o, hdata, hlast);
                end
            end
            inflight = rd_req_cnt - rd0 - k + (tcm_req_o === 1'b1 ? 1 : 0);
            total++;
            if (inflight > DEPTH) begin
                bad++;
                $display("FAIL read_credit: buffered+outstanding=%0d required <= %0d", inflight, DEPTH);
            end
            if (m_valid_o === 1'b1 && m_ready_i) begin
                exp = exp_mem[a0 + 32'(4 * k)];
                total++;
                if (m_data_o !== exp || m_last_o !== (k == n - 1)) begin
                    bad++;
                    $display("FAIL read_data: word %0d data=%h last=%b required %h %b",
                             k, m_data_o, m_last_o, exp, (k == n - 1));
                end
                k++;
                last_cyc = cyc;
                held = 1'b0;
            end else begin
                held = (m_valid_o === 1'b1);
                hdata = m_data_o;
                hlast = m_last_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        m_ready_i = 1'b0;
        total++;
        if (k != n) begin
            bad++;
            $display("FAIL read_timeout: words=%0d required %0d", k, n);
        end
        #1;
        total++;
        if (done_o !== 1'b1 || m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL read_done: done=%b m_valid=%b required 1 0", done_o, m_valid_o);
        end
        total++;
        if (rd_req_cnt - rd0 != n) begin
            bad++;
            $display("FAIL read_req_count: reqs=%0d required %0d", rd_req_cnt - rd0, n);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if (!outputs_quiet()) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b req=%b busy=%b be=%h required all quiet, be=f",
                     cmd_ready_o, tcm_req_o, busy_o, tcm_be_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        total++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || m_valid_o !== 1'b0 || tcm_req_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b m_valid=%b req=%b required 1 0 0 0",
                     cmd_ready_o, busy_o, m_valid_o, tcm_req_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_write_basic();
        do_write(32'h100, 4, 0, 1'b1, 32'hA0);
    endtask

    task automatic test_read_backpressure();
        int fr, fv, lc;
        do_read(32'h100, 4, 1, fr, fv, lc);
    endtask

    task automatic test_read_latency();
        int fr, fv, lc;
        do_write(32'h400, 8, 0, 1'b1, 32'h400);
        do_read(32'h400, 8, 0, fr, fv, lc);
        total++;
        if (fr != 1 || fv != 3 || lc != 10) begin
            bad++;
            $display("FAIL read_latency: first_req=%0d first_valid=%0d last=%0d required 1 3 10", fr, fv, lc);
        end
    endtask

    task automatic test_zero_len();
        int rc = req_cnt;
        send_cmd(1'b1, 32'h500, 16'd0);
        #1;
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b required 1 1", done_o, busy_o);
        end
        @(negedge clk_i); #1;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || req_cnt != rc) begin
            bad++;
            $display("FAIL zero_after: done=%b busy=%b reqs=%0d required 0 0 0", done_o, busy_o, req_cnt - rc);
        end
        @(negedge clk_i);
    endtask

    task automatic test_misaligned();
        int rc = req_cnt;
        send_cmd(1'b0, 32'h102, 16'd4);
        #1;
        total++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL misaligned_err: err=%b done=%b busy=%b ready=%b required 1 0 0 1",
                     err_o, done_o, busy_o, cmd_ready_o);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i); #1;
            total++;
            if (err_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || tcm_req_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL misaligned_after: err=%b done=%b busy=%b req=%b ready=%b required 0 0 0 0 1",
                         err_o, done_o, busy_o, tcm_req_o, cmd_ready_o);
            end
        end
        total++;
        if (req_cnt != rc) begin
            bad++;
            $display("FAIL misaligned_traffic: reqs=%0d required 0", req_cnt - rc);
        end
        @(negedge clk_i);
    endtask

    task automatic test_wrap();
        int fr, fv, lc;
        do_write(32'hFFFF_FFF8, 4, 0, 1'b1, 32'hD0);
        total++;
        if (tcm_mem[32'h0000_0000] !== 32'hD2 || tcm_mem[32'h0000_0004] !== 32'hD3) begin
            bad++;
            $display("FAIL wrap_mem: [0]=%h [4]=%h required d2 d3", tcm_mem[32'h0], tcm_mem[32'h4]);
        end
        do_read(32'hFFFF_FFF8, 4, 2, fr, fv, lc);
    endtask

    task automatic test_reset_mid_read();
        int fr, fv, lc;
        int k = 0;
        int cyc = 0;
        do_write(32'h200, 8, 0, 1'b1, 32'hB0);
        do_write(32'h300, 2, 0, 1'b1, 32'hC0);
        send_cmd(1'b0, 32'h200, 16'd8);
        m_ready_i = 1'b1;
        while (k < 3 && cyc < 50) begin
            #1;
            if (m_valid_o === 1'b1) k++;
            @(negedge clk_i);
            cyc++;
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if (!outputs_quiet()) begin
            bad++;
            $display("FAIL midreset_outputs: req=%b m_valid=%b busy=%b done=%b ready=%b required all quiet",
                     tcm_req_o, m_valid_o, busy_o, done_o, cmd_ready_o);
        end
        #1;
        rst_ni = 1'b1;
        m_ready_i = 1'b0;
        @(negedge clk_i); #1;
        total++;
        if (m_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_release: m_valid=%b done=%b busy=%b ready=%b required 0 0 0 1",
                     m_valid_o, done_o, busy_o, cmd_ready_o);
        end
        @(negedge clk_i);
        do_read(32'h300, 2, 0, fr, fv, lc);
    endtask

    task automatic test_random();
        int fr, fv, lc;
        logic [31:0] a;
        int n;
        for (int it = 0; it < 8; it++) begin
            a = 32'h1000 + 32'(4 * $urandom_range(0, 32));
            n = $urandom_range(1, 10);
            do_write(a, n, 30, 1'b0, 32'h0);
            do_read(a, n, 2, fr, fv, lc);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_backpressure();
        test_read_latency();
        test_zero_len();
        test_misaligned();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
